// File: rtl/imem_uart_loader.sv
// UART-to-instruction-memory loader: unpacks a length-prefixed byte frame into
// big-endian 32-bit words, writes them at consecutive addresses, holds the CPU in reset meanwhile.
module imem_uart_loader #(
    parameter int          DEPTH          = 256,
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int          TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_req,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_hold,
    output logic        load_done,
    output logic        load_error,
    output logic [15:0] words_loaded
);

    typedef enum logic [2:0] {S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_DONE, S_ERR} state_t;

    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [16:0] DEPTH_W  = 17'(DEPTH);

    state_t      state_q, state_d;
    logic [15:0] len_q, len_d;
    logic [15:0] word_idx_q, word_idx_d;
    logic [1:0]  byte_idx_q, byte_idx_d;
    logic [23:0] asm_q, asm_d;
    logic [31:0] tmo_q, tmo_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        hold_q, hold_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [15:0] words_q, words_d;

    logic        timed;
    logic        tmo_hit;
    logic [15:0] len_full;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            word_idx_q <= '0;
            byte_idx_q <= '0;
            asm_q      <= '0;
            tmo_q      <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            hold_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            words_q    <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            word_idx_q <= word_idx_d;
            byte_idx_q <= byte_idx_d;
            asm_q      <= asm_d;
            tmo_q      <= tmo_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            hold_q     <= hold_d;
            done_q     <= done_d;
            err_q      <= err_d;
            words_q    <= words_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        word_idx_d = word_idx_q;
        byte_idx_d = byte_idx_q;
        asm_d      = asm_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        hold_d     = hold_q;
        done_d     = 1'b0;
        err_d      = err_q;
        words_d    = words_q;
        len_full   = {len_q[15:8], rx_data};

        timed   = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) || (state_q == S_DATA);
        tmo_d   = timed ? tmo_q + 32'd1 : '0;
        // An arriving byte always beats the terminal count.
        tmo_hit = timed && !rx_valid && (tmo_q == TMO_LAST);

        case (state_q)
            S_IDLE, S_ERR: begin
                if (load_req) begin
                    state_d    = S_LEN_HI;
                    hold_d     = 1'b1;
                    err_d      = 1'b0;
                    words_d    = '0;
                    word_idx_d = '0;
                    byte_idx_d = '0;
                    tmo_d      = '0;
                end
            end
            S_LEN_HI: begin
                if (rx_valid) begin
                    len_d   = {rx_data, len_q[7:0]};
                    tmo_d   = '0;
                    state_d = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (rx_valid) begin
                    len_d      = len_full;
                    tmo_d      = '0;
                    word_idx_d = '0;
                    byte_idx_d = '0;
                    if (len_full == 16'd0) begin
                        state_d = S_DONE;
                    end else if ({1'b0, len_full} > DEPTH_W) begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (rx_valid) begin
                    asm_d      = {asm_q[15:0], rx_data};
                    byte_idx_d = byte_idx_q + 2'd1;
                    tmo_d      = '0;
                    if (byte_idx_q == 2'd3) begin
                        we_d       = 1'b1;
                        wdata_d    = {asm_q, rx_data};
                        addr_d     = BASE_ADDR + 32'({word_idx_q, 2'b00});
                        words_d    = word_idx_q + 16'd1;
                        word_idx_d = word_idx_q + 16'd1;
                        if (word_idx_q == len_q - 16'd1) begin
                            state_d = S_DONE;
                        end
                    end
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                hold_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (tmo_hit) begin
            state_d = S_ERR;
            err_d   = 1'b1;
            tmo_d   = '0;
        end
    end

    assign imem_we      = we_q;
    assign imem_addr    = addr_q;
    assign imem_wdata   = wdata_q;
    assign cpu_hold     = hold_q;
    assign load_done    = done_q;
    assign load_error   = err_q;
    assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_uart_loader.sv
// Bench for imem_uart_loader: frames with random gaps and payloads, checked against
// expectations computed from the frame contents and the byte arrival cycles.
module tb_imem_uart_loader;

    localparam int          DEPTH   = 256;
    localparam logic [31:0] BASE    = 32'h0000_0100;
    localparam int          TIMEOUT = 100;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load_req = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_hold;
    logic        load_done;
    logic        load_error;
    logic [15:0] words_loaded;

    imem_uart_loader #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .load_req(load_req), .rx_data(rx_data), .rx_valid(rx_valid),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata), .cpu_hold(cpu_hold),
        .load_done(load_done), .load_error(load_error), .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [31:0] addr;
        logic [31:0] data;
        logic [15:0] wl;
    } wr_t;

    int         tests = 0;
    int         fails = 0;
    int         cyc = 0;
    wr_t        wq[$];
    int         dq[$];
    int         hq[$];
    int         bcyc[$];
    logic [7:0] frame[$];
    int         mid_req_at = -1;
    logic       prev_hold = 1'b0;

    always @(posedge clk) cyc++;

    // Passive monitor: log writes, done pulses and cpu_hold falling edges with their cycle.
    always @(negedge clk) begin
        if (imem_we) wq.push_back('{cyc, imem_addr, imem_wdata, words_loaded});
        if (load_done) dq.push_back(cyc);
        if (prev_hold && !cpu_hold) hq.push_back(cyc);
        prev_hold = cpu_hold;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish within budget");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, input logic req);
        rx_data  = b;
        rx_valid = 1'b1;
        load_req = req;
        bcyc.push_back(cyc);
        tick();
        rx_valid = 1'b0;
        load_req = 1'b0;
        for (int g = 0; g < gap; g++) tick();
    endtask

    task automatic clear_logs();
        wq.delete();
        dq.delete();
        hq.delete();
        bcyc.delete();
    endtask

    task automatic start_load(input string tag);
        clear_logs();
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
        check({tag, "_hold_start"}, 64'(cpu_hold), 64'd1);
        check({tag, "_wl_start"}, 64'(words_loaded), 64'd0);
        check({tag, "_err_start"}, 64'(load_error), 64'd0);
    endtask

    // Sends the global frame and checks the outcome derived from its length field.
    task automatic run_frame(input string tag);
        int n;
        int last;
        logic [31:0] w;
        start_load(tag);
        foreach (frame[i]) send_byte(frame[i], $urandom_range(0, 3), (i == mid_req_at));
        mid_req_at = -1;
        for (int k = 0; k < 4; k++) tick();
        n    = (int'(frame[0]) << 8) | int'(frame[1]);
        last = bcyc[bcyc.size() - 1];
        if (n > DEPTH) begin
            check({tag, "_nwrites"}, 64'(wq.size()), 64'd0);
            check({tag, "_err"}, 64'(load_error), 64'd1);
            check({tag, "_hold"}, 64'(cpu_hold), 64'd1);
            check({tag, "_ndone"}, 64'(dq.size()), 64'd0);
        end else begin
            check({tag, "_nwrites"}, 64'(wq.size()), 64'(n));
            for (int i = 0; i < n && i < wq.size(); i++) begin
                w = {frame[2 + 4*i], frame[3 + 4*i], frame[4 + 4*i], frame[5 + 4*i]};
                check($sformatf("%s_addr%0d", tag, i), 64'(wq[i].addr), 64'(BASE + 32'(4*i)));
                check($sformatf("%s_data%0d", tag, i), 64'(wq[i].data), 64'(w));
                check($sformatf("%s_wcyc%0d", tag, i), 64'(wq[i].cyc), 64'(bcyc[5 + 4*i] + 1));
                check($sformatf("%s_wl%0d", tag, i), 64'(wq[i].wl), 64'(i + 1));
            end
            check({tag, "_ndone"}, 64'(dq.size()), 64'd1);
            if (dq.size() > 0) check({tag, "_done_cyc"}, 64'(dq[0]), 64'(last + 2));
            check({tag, "_nfall"}, 64'(hq.size()), 64'd1);
            if (hq.size() > 0) check({tag, "_fall_cyc"}, 64'(hq[0]), 64'(last + 2));
            check({tag, "_wl_end"}, 64'(words_loaded), 64'(n));
            check({tag, "_err"}, 64'(load_error), 64'd0);
        end
    endtask

    task automatic random_frame(input int n);
        frame.delete();
        frame.push_back(8'(n >> 8));
        frame.push_back(8'(n));
        for (int i = 0; i < 4*n; i++) frame.push_back(8'($urandom_range(0, 255)));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_we"}, 64'(imem_we), 64'd0);
        check({tag, "_addr"}, 64'(imem_addr), 64'd0);
        check({tag, "_wdata"}, 64'(imem_wdata), 64'd0);
        check({tag, "_hold"}, 64'(cpu_hold), 64'd0);
        check({tag, "_done"}, 64'(load_done), 64'd0);
        check({tag, "_err"}, 64'(load_error), 64'd0);
        check({tag, "_wl"}, 64'(words_loaded), 64'd0);
    endtask

    initial begin
        int t;
        reset = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        check_all_zero("reset");
        reset = 1'b0;
        tick();

        // Spec example: two words.
        frame = '{8'h00, 8'h02, 8'h08, 8'h00, 8'h00, 8'h03, 8'h3C, 8'h10, 8'h40, 8'h00};
        run_frame("two_words");

        // Empty frame.
        frame = '{8'h00, 8'h00};
        run_frame("empty");

        // Randomised frames.
        for (int r = 0; r < 3; r++) begin
            random_frame($urandom_range(1, 6));
            run_frame($sformatf("rand%0d", r));
        end

        // Oversize length, then recovery from ERR.
        frame = '{8'h01, 8'h01};
        run_frame("oversize");
        random_frame(1);
        run_frame("recover");

        // Largest legal frame fills memory exactly.
        random_frame(DEPTH);
        run_frame("full_depth");

        // Timeout: ERR exactly TIMEOUT edges after the last byte.
        start_load("tmo");
        send_byte(8'h00, 0, 1'b0);
        send_byte(8'h01, 0, 1'b0);
        send_byte(8'hAA, 0, 1'b0);
        send_byte(8'hBB, 0, 1'b0);
        t = bcyc[3];
        while (cyc < t + TIMEOUT) tick();
        check("tmo_before", 64'(load_error), 64'd0);
        tick();
        check("tmo_err", 64'(load_error), 64'd1);
        check("tmo_hold", 64'(cpu_hold), 64'd1);
        check("tmo_nwrites", 64'(wq.size()), 64'd0);

        // Bytes arriving exactly on the terminal cycle keep the load alive.
        start_load("tmo_edge");
        send_byte(8'h00, 0, 1'b0);
        send_byte(8'h01, 0, 1'b0);
        send_byte(8'hAA, 0, 1'b0);
        while (cyc < bcyc[2] + TIMEOUT) tick();
        send_byte(8'hBB, 0, 1'b0);
        while (cyc < bcyc[3] + TIMEOUT) tick();
        send_byte(8'hCC, 0, 1'b0);
        send_byte(8'hDD, 0, 1'b0);
        for (int k = 0; k < 4; k++) tick();
        check("tmo_edge_err", 64'(load_error), 64'd0);
        check("tmo_edge_nwrites", 64'(wq.size()), 64'd1);
        if (wq.size() > 0) check("tmo_edge_data", 64'(wq[0].data), 64'hAABBCCDD);
        check("tmo_edge_ndone", 64'(dq.size()), 64'd1);

        // Bytes in IDLE are ignored.
        clear_logs();
        for (int k = 0; k < 6; k++) send_byte(8'($urandom_range(0, 255)), 0, 1'b0);
        tick();
        check("idle_nwrites", 64'(wq.size()), 64'd0);
        check("idle_hold", 64'(cpu_hold), 64'd0);
        check("idle_err", 64'(load_error), 64'd0);

        // load_req during DATA is ignored.
        random_frame(3);
        mid_req_at = 7;
        run_frame("mid_req");

        // Reset mid-load, then a fresh load restarts at BASE.
        random_frame(3);
        start_load("rst");
        for (int i = 0; i < 10; i++) send_byte(frame[i], $urandom_range(0, 2), 1'b0);
        tick();
        check("rst_partial", 64'(wq.size()), 64'd2);
        reset = 1'b1;
        tick();
        check_all_zero("rst_mid");
        reset = 1'b0;
        tick();
        random_frame(1);
        run_frame("after_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
